// File: rtl/ascon_fsm_moore.sv
// ASCON-AEAD128 Moore control FSM: INIT(p12), DA(p8), TC1(p8), TC2(p8), FINAL(p12).
// Outputs are registered from the next state, so they always match the state register.
module ascon_fsm_moore (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [3:0] round_i,
  output logic       init_o,
  output logic       enable_p_o,
  output logic       enable_xor_b_o,
  output logic [1:0] enable_xor_e_o,
  output logic       active_round_o,
  output logic       init_round_p12_o,
  output logic       init_round_p8_o,
  output logic       enable_tag_register,
  output logic       enable_cipher_register,
  output logic       cipher_valid_o,
  output logic       end_o,
  output logic       end_init_o,
  output logic       end_da_o,
  output logic       end_tc_o,
  output logic       end_final_o
);

  typedef enum logic [4:0] {
    IDLE, CONF_INIT, INIT_RND, INIT_LAST, WAIT_DA,
    CONF_DA, DA_FIRST, DA_RND, DA_LAST, WAIT_TC1,
    CONF_TC1, TC1_FIRST, TC1_RND, TC1_LAST, WAIT_TC2,
    CONF_TC2, TC2_FIRST, TC2_RND, TC2_LAST, WAIT_FIN,
    CONF_FIN, FIN_FIRST, FIN_RND, FIN_LAST, END
  } state_t;

  typedef struct packed {
    logic       init;
    logic       p;
    logic       xb;
    logic [1:0] xe;
    logic       act;
    logic       p12;
    logic       p8;
    logic       tag;
    logic       ci;
    logic       cv;
    logic       fin;
    logic       e_init;
    logic       e_da;
    logic       e_tc;
    logic       e_final;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl;
  ctl_t   ctl_q;
  logic   r10;

  assign r10 = (round_i == 4'd10);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (start_i) nxt = CONF_INIT;
      CONF_INIT: nxt = INIT_RND;
      INIT_RND:  if (r10) nxt = INIT_LAST;
      INIT_LAST: nxt = WAIT_DA;
      WAIT_DA:   if (data_valid_i) nxt = CONF_DA;
      CONF_DA:   nxt = DA_FIRST;
      DA_FIRST:  nxt = DA_RND;
      DA_RND:    if (r10) nxt = DA_LAST;
      DA_LAST:   nxt = WAIT_TC1;
      WAIT_TC1:  if (data_valid_i) nxt = CONF_TC1;
      CONF_TC1:  nxt = TC1_FIRST;
      TC1_FIRST: nxt = TC1_RND;
      TC1_RND:   if (r10) nxt = TC1_LAST;
      TC1_LAST:  nxt = WAIT_TC2;
      WAIT_TC2:  if (data_valid_i) nxt = CONF_TC2;
      CONF_TC2:  nxt = TC2_FIRST;
      TC2_FIRST: nxt = TC2_RND;
      TC2_RND:   if (r10) nxt = TC2_LAST;
      TC2_LAST:  nxt = WAIT_FIN;
      WAIT_FIN:  if (data_valid_i) nxt = CONF_FIN;
      CONF_FIN:  nxt = FIN_FIRST;
      FIN_FIRST: nxt = FIN_RND;
      FIN_RND:   if (r10) nxt = FIN_LAST;
      FIN_LAST:  nxt = END;
      END:       if (start_i) nxt = CONF_INIT;
      default:   nxt = IDLE;
    endcase
  end

  // Output decode of the state about to be entered.
  always_comb begin
    ctl = '0;
    case (nxt)
      CONF_INIT: begin
        ctl.init = 1'b1;
        ctl.p12  = 1'b1;
      end
      INIT_RND, DA_RND, TC1_RND, TC2_RND, FIN_RND: begin
        ctl.p   = 1'b1;
        ctl.act = 1'b1;
      end
      INIT_LAST: begin
        ctl.p  = 1'b1;
        ctl.xe = 2'b01;
      end
      WAIT_DA:  ctl.e_init = 1'b1;
      CONF_DA, CONF_TC1, CONF_TC2: ctl.p8 = 1'b1;
      CONF_FIN: ctl.p12 = 1'b1;
      DA_FIRST: begin
        ctl.p   = 1'b1;
        ctl.xb  = 1'b1;
        ctl.act = 1'b1;
      end
      TC1_FIRST, TC2_FIRST, FIN_FIRST: begin
        ctl.p   = 1'b1;
        ctl.xb  = 1'b1;
        ctl.act = 1'b1;
        ctl.ci  = 1'b1;
      end
      DA_LAST: begin
        ctl.p  = 1'b1;
        ctl.xe = 2'b10;
      end
      TC1_LAST, TC2_LAST: ctl.p = 1'b1;
      FIN_LAST: begin
        ctl.p   = 1'b1;
        ctl.xe  = 2'b01;
        ctl.tag = 1'b1;
      end
      WAIT_TC1: ctl.e_da = 1'b1;
      WAIT_TC2, WAIT_FIN: begin
        ctl.e_tc = 1'b1;
        ctl.cv   = 1'b1;
      end
      END: begin
        ctl.fin     = 1'b1;
        ctl.e_final = 1'b1;
        ctl.cv      = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= IDLE;
      ctl_q <= '0;
    end else begin
      state <= nxt;
      ctl_q <= ctl;
    end
  end

  assign init_o                 = ctl_q.init;
  assign enable_p_o             = ctl_q.p;
  assign enable_xor_b_o         = ctl_q.xb;
  assign enable_xor_e_o         = ctl_q.xe;
  assign active_round_o         = ctl_q.act;
  assign init_round_p12_o       = ctl_q.p12;
  assign init_round_p8_o        = ctl_q.p8;
  assign enable_tag_register    = ctl_q.tag;
  assign enable_cipher_register = ctl_q.ci;
  assign cipher_valid_o         = ctl_q.cv;
  assign end_o                  = ctl_q.fin;
  assign end_init_o             = ctl_q.e_init;
  assign end_da_o               = ctl_q.e_da;
  assign end_tc_o               = ctl_q.e_tc;
  assign end_final_o            = ctl_q.e_final;

endmodule

// File: tb/tb_ascon_fsm_moore.sv
// Scoreboarded bench for ascon_fsm_moore: random handshakes, per-phase records
// compared against a phase-level reference model, plus a mid-run reset.
module tb_ascon_fsm_moore;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic [3:0] round_i;
  logic       init_o, enable_p_o, enable_xor_b_o, active_round_o;
  logic [1:0] enable_xor_e_o;
  logic       init_round_p12_o, init_round_p8_o;
  logic       enable_tag_register, enable_cipher_register;
  logic       cipher_valid_o, end_o, end_init_o, end_da_o;
  logic       end_tc_o, end_final_o;

  ascon_fsm_moore dut (
    .clock_i(clock_i), .resetb_i(resetb_i),
    .start_i(start_i), .data_valid_i(data_valid_i),
    .round_i(round_i), .init_o(init_o),
    .enable_p_o(enable_p_o), .enable_xor_b_o(enable_xor_b_o),
    .enable_xor_e_o(enable_xor_e_o), .active_round_o(active_round_o),
    .init_round_p12_o(init_round_p12_o),
    .init_round_p8_o(init_round_p8_o),
    .enable_tag_register(enable_tag_register),
    .enable_cipher_register(enable_cipher_register),
    .cipher_valid_o(cipher_valid_o), .end_o(end_o),
    .end_init_o(end_init_o), .end_da_o(end_da_o),
    .end_tc_o(end_tc_o), .end_final_o(end_final_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [3:0] n_init;
    logic [3:0] n_p12;
    logic [3:0] n_p8;
    logic [4:0] n_p;
    logic [4:0] n_xb;
    logic [4:0] n_ci;
    logic [4:0] n_xe;
    logic [4:0] n_tag;
    logic [1:0] xe_last;
    logic [5:0] flags;
  } rec_t;

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];
  logic [3:0] cnt;

  wire [15:0] outs = {init_o, enable_p_o, enable_xor_b_o, enable_xor_e_o,
                      active_round_o, init_round_p12_o, init_round_p8_o,
                      enable_tag_register, enable_cipher_register,
                      cipher_valid_o, end_o, end_init_o, end_da_o,
                      end_tc_o, end_final_o};

  // Datapath round counter stand-in.
  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) cnt <= 4'd0;
    else if (init_round_p12_o) cnt <= 4'd0;
    else if (init_round_p8_o) cnt <= 4'd4;
    else if (active_round_o) cnt <= cnt + 4'd1;
  end
  assign round_i = cnt;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Phase 0=INIT 1=DA 2=TC1 3=TC2 4=FINAL.
  function automatic rec_t expect_rec(input int ph);
    rec_t r;
    bit   long_p;
    r       = '0;
    long_p  = (ph == 0) || (ph == 4);
    r.n_init = (ph == 0) ? 4'd1 : 4'd0;
    r.n_p12  = long_p ? 4'd1 : 4'd0;
    r.n_p8   = long_p ? 4'd0 : 4'd1;
    r.n_p    = long_p ? 5'd12 : 5'd8;
    r.n_xb   = (ph == 0) ? 5'd0 : 5'd1;
    r.n_ci   = (ph >= 2) ? 5'd1 : 5'd0;
    r.xe_last = (ph == 0 || ph == 4) ? 2'b01 : (ph == 1) ? 2'b10 : 2'b00;
    r.n_xe   = (r.xe_last != 2'b00) ? 5'd1 : 5'd0;
    r.n_tag  = (ph == 4) ? 5'd1 : 5'd0;
    // {end, end_init, end_da, end_tc, end_final, cipher_valid}
    case (ph)
      0: r.flags = 6'b010000;
      1: r.flags = 6'b001000;
      2, 3: r.flags = 6'b000101;
      default: r.flags = 6'b100011;
    endcase
    return r;
  endfunction

  function automatic bit wait_flag(input int ph);
    case (ph)
      1: return end_init_o;
      2: return end_da_o;
      default: return end_tc_o;
    endcase
  endfunction

  // Monitor: one record per permutation burst, closed on the first idle cycle.
  initial begin
    rec_t acc;
    acc = '0;
    forever begin
      @(negedge clock_i);
      if (!resetb_i) acc = '0;
      else begin
        if (init_o) acc.n_init++;
        if (init_round_p12_o) acc.n_p12++;
        if (init_round_p8_o) acc.n_p8++;
        if (enable_xor_b_o) acc.n_xb++;
        if (enable_cipher_register) acc.n_ci++;
        if (enable_tag_register) acc.n_tag++;
        if (enable_xor_e_o != 2'b00) acc.n_xe++;
        if (enable_p_o) begin
          acc.n_p++;
          if (enable_xor_e_o != 2'b00) acc.xe_last = enable_xor_e_o;
        end else if (acc.n_p != 5'd0) begin
          acc.flags = {end_o, end_init_o, end_da_o, end_tc_o,
                       end_final_o, cipher_valid_o};
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_phase actual=%h required=none", acc);
          end else begin
            check("phase_record", 64'(acc), 64'(exp_q.pop_front()));
          end
          acc = '0;
        end
      end
    end
  end

  task automatic run_once(input bit mid_reset);
    int guard;
    @(negedge clock_i);
    start_i = 1'b1;
    data_valid_i = 1'($urandom_range(0, 1));
    exp_q.push_back(expect_rec(0));
    @(negedge clock_i);
    start_i = 1'b0;
    data_valid_i = 1'b0;
    check("conf_init", {init_o, init_round_p12_o, end_o}, 3'b110);
    @(negedge clock_i);
    check("init_single", {init_o, init_round_p12_o}, 2'b00);
    for (int ph = 1; ph <= 4; ph++) begin
      guard = 0;
      while (!wait_flag(ph) && guard < 300) begin
        start_i = enable_p_o ? 1'($urandom_range(0, 1)) : 1'b0;
        data_valid_i = enable_p_o ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clock_i);
        guard++;
      end
      start_i = 1'b0;
      data_valid_i = 1'b0;
      if (guard >= 300) begin
        checks++;
        failures++;
        $display("FAIL wait_phase_timeout actual=%0d required=%0d", guard, ph);
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        start_i = 1'($urandom_range(0, 1));
        @(negedge clock_i);
      end
      data_valid_i = 1'b1;
      start_i = 1'($urandom_range(0, 1));
      exp_q.push_back(expect_rec(ph));
      @(negedge clock_i);
      data_valid_i = 1'b0;
      start_i = 1'b0;
      if (mid_reset && ph == 2) begin
        guard = 0;
        while (!(enable_p_o && round_i == 4'd7) && guard < 100) begin
          @(negedge clock_i);
          guard++;
        end
        check("tc1_round7_reached", 64'(guard < 100), 64'd1);
        #1 resetb_i = 1'b0;
        #1 check("mid_reset_outputs", 64'(outs), 64'd0);
        exp_q.delete();
        #10;
        @(negedge clock_i);
        check("reset_holds_idle", 64'(outs), 64'd0);
        resetb_i = 1'b1;
        return;
      end
    end
    guard = 0;
    while (!end_o && guard < 300) begin
      @(negedge clock_i);
      guard++;
    end
    check("end_state", {end_o, end_final_o, cipher_valid_o}, 3'b111);
    repeat ($urandom_range(1, 3)) begin
      data_valid_i = 1'($urandom_range(0, 1));
      @(negedge clock_i);
    end
    data_valid_i = 1'b0;
    check("end_holds", {end_o, init_o}, 2'b10);
  endtask

  initial begin
    #3 check("reset_outputs", 64'(outs), 64'd0);
    #9 resetb_i = 1'b1;
    run_once(1'b0);
    run_once(1'b1);
    repeat (3) run_once(1'b0);
    repeat (2) @(negedge clock_i);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
